// File: rtl/core_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: round-robin on ties, per-grant
// outstanding-request tracking and a timeout that aborts a hung cycle.
module core_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic [31:0] m0_wb_data_i,
    input  logic [27:0] m0_wb_adr_i,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_stall_o,
    output logic        m0_wb_error_o,
    output logic [31:0] m0_wb_data_o,
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic [31:0] m1_wb_data_i,
    input  logic [27:0] m1_wb_adr_i,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_stall_o,
    output logic        m1_wb_error_o,
    output logic [31:0] m1_wb_data_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_data_o,
    output logic [27:0] wb_adr_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    input  logic        wb_error_i,
    input  logic [31:0] wb_data_i
);
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

    state_t      state_q, state_d, st;
    logic        last_q, last_d;
    logic [2:0]  outst_q, outst_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        gnt1, active, live, hit, fire, accept, ab_cyc;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_dat;
    logic [27:0] s_adr;

    assign m0_wb_data_o = wb_data_i;
    assign m1_wb_data_o = wb_data_i;

    // Reset forces the IDLE view combinationally so outputs are safe before the first edge.
    always_comb begin
        st     = wb_rst_i ? IDLE : state_q;
        gnt1   = (st == GRANT1);
        active = (st == GRANT0) || (st == GRANT1);
        s_cyc  = gnt1 ? m1_wb_cyc_i  : m0_wb_cyc_i;
        s_stb  = gnt1 ? m1_wb_stb_i  : m0_wb_stb_i;
        s_we   = gnt1 ? m1_wb_we_i   : m0_wb_we_i;
        s_sel  = gnt1 ? m1_wb_sel_i  : m0_wb_sel_i;
        s_dat  = gnt1 ? m1_wb_data_i : m0_wb_data_i;
        s_adr  = gnt1 ? m1_wb_adr_i  : m0_wb_adr_i;
        live   = active && s_cyc;
        hit    = live && (wb_ack_i || wb_error_i);
        fire   = live && !hit && (tmo_q == TMO);
        accept = live && !fire && s_stb && !wb_stall_i;
        ab_cyc = last_q ? m1_wb_cyc_i : m0_wb_cyc_i;
    end

    always_comb begin
        wb_cyc_o      = 1'b0;
        wb_stb_o      = 1'b0;
        wb_we_o       = 1'b0;
        wb_sel_o      = '0;
        wb_data_o     = '0;
        wb_adr_o      = '0;
        m0_wb_stall_o = 1'b1;
        m0_wb_ack_o   = 1'b0;
        m0_wb_error_o = 1'b0;
        m1_wb_stall_o = 1'b1;
        m1_wb_ack_o   = 1'b0;
        m1_wb_error_o = 1'b0;
        if (active) begin
            wb_cyc_o  = s_cyc && !fire;
            wb_stb_o  = s_cyc && s_stb && !fire;
            wb_we_o   = s_we;
            wb_sel_o  = s_sel;
            wb_data_o = s_dat;
            wb_adr_o  = s_adr;
            if (gnt1) begin
                m1_wb_stall_o = fire || wb_stall_i;
                m1_wb_ack_o   = live && wb_ack_i;
                m1_wb_error_o = live && (wb_error_i || fire);
            end else begin
                m0_wb_stall_o = fire || wb_stall_i;
                m0_wb_ack_o   = live && wb_ack_i;
                m0_wb_error_o = live && (wb_error_i || fire);
            end
        end
    end

    always_comb begin
        state_d = st;
        last_d  = last_q;
        outst_d = outst_q;
        tmo_d   = '0;
        case (st)
            IDLE: begin
                outst_d = '0;
                if (m0_wb_cyc_i && m1_wb_cyc_i) state_d = last_q ? GRANT0 : GRANT1;
                else if (m0_wb_cyc_i)           state_d = GRANT0;
                else if (m1_wb_cyc_i)           state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (!s_cyc) begin
                    state_d = IDLE;
                    last_d  = gnt1;
                    outst_d = '0;
                end else if (fire) begin
                    // last_q doubles as the aborted-master index while in ABORT
                    state_d = ABORT;
                    last_d  = gnt1;
                end else begin
                    if (accept && !hit && outst_q != 3'd7)
                        outst_d = outst_q + 3'd1;
                    else if (hit && !accept && outst_q != 3'd0)
                        outst_d = outst_q - 3'd1;
                    if (hit)
                        tmo_d = '0;
                    else if ((outst_q != 3'd0 || s_stb) && tmo_q != 8'hFF)
                        tmo_d = tmo_q + 8'd1;
                    else
                        tmo_d = tmo_q;
                end
            end
            ABORT: begin
                if (!ab_cyc) begin
                    state_d = IDLE;
                    outst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            outst_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule
